mnist_prediction_tx: RTL

//  Output stage of the mnist classifier. Captures the final layer's class-score vector
//  in parallel and streams it out one class per beat, class 0 first, on the

---
 rtl/mnist_prediction_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mnist_prediction_tx.sv
// mnist_prediction_tx: output stage of the mnist classifier.
// Captures a full class-score vector in one cycle, streams it out one class
// per beat (class 0 first) on a valid/ready interface, and tracks the signed
// argmax while streaming so the winning class can be pulsed out right after
// the last beat.
module mnist_prediction_tx #(
   parameter  int NUM_CLASSES = 10,
   parameter  int DATA_W      = 16,
   localparam int CNT_W       = $clog2(NUM_CLASSES)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_CLASSES*DATA_W-1:0] scores_in,
   input  logic                          scores_in_valid,
   output logic                          scores_in_ready,
   output logic [DATA_W-1:0]             prediction_out,
   output logic                          prediction_out_valid,
   input  logic                          prediction_out_ready,
   output logic                          prediction_out_last,
   output logic [CNT_W-1:0]              prediction_index,
   output logic [CNT_W-1:0]              class_out,
   output logic                          class_valid
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CLASSES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic signed [DATA_W-1:0] buffer_q [NUM_CLASSES];
   logic signed [DATA_W-1:0] best_q;
   logic [CNT_W-1:0]         best_idx_q;
   logic [CNT_W-1:0]         next_idx;
   logic                     load;
   logic                     xfer;
   logic                     last_xfer;
   logic                     beat_wins;

   assign prediction_out_valid = (state_q == SEND);
   assign xfer                 = prediction_out_valid && prediction_out_ready;
   assign last_xfer            = xfer && prediction_out_last;
   assign load                 = scores_in_valid && scores_in_ready;
   assign next_idx             = prediction_index + CNT_W'(1);

   // Beat 0 always seeds the running best; later beats win only when strictly
   // greater, so ties keep the lower class index.
   assign beat_wins = (prediction_index == '0) || ($signed(prediction_out) > best_q);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and input handshake; a new vector may be taken on the same
   // edge the last beat leaves, which keeps back-to-back vectors bubble free.
   always_comb begin
      state_d         = state_q;
      scores_in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            scores_in_ready = 1'b1;
            if (scores_in_valid) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (last_xfer) begin
               scores_in_ready = 1'b1;
               if (!scores_in_valid) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Vector buffer and the registered beat outputs; the beat only advances on
   // a transfer, so data and index hold steady through stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            buffer_q[c] <= '0;
         end
         prediction_out      <= '0;
         prediction_index    <= '0;
         prediction_out_last <= 1'b0;
      end else if (load) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            buffer_q[c] <= scores_in[c*DATA_W +: DATA_W];
         end
         prediction_out      <= scores_in[DATA_W-1:0];
         prediction_index    <= '0;
         prediction_out_last <= (NUM_CLASSES == 1);
      end else if (xfer && !prediction_out_last) begin
         prediction_out      <= buffer_q[next_idx];
         prediction_index    <= next_idx;
         prediction_out_last <= (next_idx == LAST_IDX);
      end
   end

   // Running argmax over transferred beats, and the one-cycle result pulse
   // issued after the last beat of each vector.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         best_q      <= '0;
         best_idx_q  <= '0;
         class_out   <= '0;
         class_valid <= 1'b0;
      end else begin
         class_valid <= last_xfer;
         if (xfer && beat_wins) begin
            best_q     <= $signed(prediction_out);
            best_idx_q <= prediction_index;
         end
         if (last_xfer) begin
            class_out <= beat_wins ? prediction_index : best_idx_q;
         end
      end
   end

endmodule
